bf_radix2_pipe: RTL and testbench

BF_RADIX2_PIPE -- requirements
Module: bf_radix2_pipe

---
 rtl/bf_radix2_pipe.sv | 140 ++++++++++++++
 tb/tb_bf_radix2_pipe.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bf_radix2_pipe.sv
// Radix-2 DIT butterfly Y0=A+B, Y1=(A-B)*W; BF_RADIX2_SAT_EN selects saturation over wrap on overflow.
// Latency: 3 register stages, so out_valid rises on the third rising edge counting the accepting edge.
// Backpressure: a single global enable stalls every stage while out_valid & ~out_ready; in_ready equals that enable.
module bf_radix2_pipe #(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8,
   parameter int TW_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] A_re,
   input  logic [DATA_W-1:0] A_im,
   input  logic [DATA_W-1:0] B_re,
   input  logic [DATA_W-1:0] B_im,
   input  logic [TW_W-1:0]   W_re,
   input  logic [TW_W-1:0]   W_im,
   input  logic              scale,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] Y0_re,
   output logic [DATA_W-1:0] Y0_im,
   output logic [DATA_W-1:0] Y1_re,
   output logic [DATA_W-1:0] Y1_im,
   output logic              ovf,
   input  logic              ovf_clr
);
   localparam int SW = DATA_W + 1;
   localparam int PW = DATA_W + TW_W + 1;
   localparam int RW = PW + 2;
   localparam logic signed [RW-1:0] MAXV = {{(RW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [RW-1:0] MINV = ~MAXV;
   localparam logic signed [RW-1:0] RND0 = RW'(2**(FRAC_W-1));
   localparam logic signed [RW-1:0] RND1 = RW'(2**FRAC_W);

   // Returns {overflow, fitted DATA_W result}
   function automatic logic [DATA_W:0] fit(input logic signed [RW-1:0] v);
      logic              o;
      logic [DATA_W-1:0] d;
      o = (v > MAXV) || (v < MINV);
      d = v[DATA_W-1:0];
`ifdef BF_RADIX2_SAT_EN
      if (o) d = v[RW-1] ? MINV[DATA_W-1:0] : MAXV[DATA_W-1:0];
`endif
      return {o, d};
   endfunction

   logic en;
   assign en       = out_ready | ~out_valid;
   assign in_ready = en;

   logic                   v1, sc1;
   logic signed [SW-1:0]   s1_re, s1_im, d1_re, d1_im;
   logic signed [TW_W-1:0] w1_re, w1_im;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0; sc1 <= 1'b0;
         s1_re <= '0; s1_im <= '0; d1_re <= '0; d1_im <= '0;
         w1_re <= '0; w1_im <= '0;
      end else if (en) begin
         v1    <= in_valid;
         sc1   <= scale;
         s1_re <= SW'($signed(A_re)) + SW'($signed(B_re));
         s1_im <= SW'($signed(A_im)) + SW'($signed(B_im));
         d1_re <= SW'($signed(A_re)) - SW'($signed(B_re));
         d1_im <= SW'($signed(A_im)) - SW'($signed(B_im));
         w1_re <= $signed(W_re);
         w1_im <= $signed(W_im);
      end
   end

   logic signed [PW-1:0] p_xc, p_ys, p_xs, p_yc;
   assign p_xc = PW'(d1_re) * PW'(w1_re);
   assign p_ys = PW'(d1_im) * PW'(w1_im);
   assign p_xs = PW'(d1_re) * PW'(w1_im);
   assign p_yc = PW'(d1_im) * PW'(w1_re);

   logic                 v2, sc2;
   logic signed [SW-1:0] s2_re, s2_im;
   logic signed [PW-1:0] xc, ys, xs, yc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2 <= 1'b0; sc2 <= 1'b0; s2_re <= '0; s2_im <= '0;
         xc <= '0; ys <= '0; xs <= '0; yc <= '0;
      end else if (en) begin
         v2    <= v1;
         sc2   <= sc1;
         s2_re <= s1_re;
         s2_im <= s1_im;
         xc    <= p_xc;
         ys    <= p_ys;
         xs    <= p_xs;
         yc    <= p_yc;
      end
   end

   // Combine, round half-up, then range check on the wide value
   logic signed [RW-1:0] re_w, im_w, r1_re, r1_im, r0_re, r0_im;
   logic [DATA_W:0]      f0_re, f0_im, f1_re, f1_im;
   logic                 beat_ovf;

   assign re_w  = RW'(xc) - RW'(ys);
   assign im_w  = RW'(xs) + RW'(yc);
   assign r1_re = sc2 ? ((re_w + RND1) >>> (FRAC_W+1)) : ((re_w + RND0) >>> FRAC_W);
   assign r1_im = sc2 ? ((im_w + RND1) >>> (FRAC_W+1)) : ((im_w + RND0) >>> FRAC_W);
   assign r0_re = sc2 ? ((RW'(s2_re) + RW'(1)) >>> 1) : RW'(s2_re);
   assign r0_im = sc2 ? ((RW'(s2_im) + RW'(1)) >>> 1) : RW'(s2_im);
   assign f0_re = fit(r0_re);
   assign f0_im = fit(r0_im);
   assign f1_re = fit(r1_re);
   assign f1_im = fit(r1_im);
   assign beat_ovf = f0_re[DATA_W] | f0_im[DATA_W] | f1_re[DATA_W] | f1_im[DATA_W];

   logic ovf_evt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         Y0_re <= '0; Y0_im <= '0; Y1_re <= '0; Y1_im <= '0;
         ovf_evt <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         if (en) begin
            out_valid <= v2;
            if (v2) begin
               Y0_re <= f0_re[DATA_W-1:0];
               Y0_im <= f0_im[DATA_W-1:0];
               Y1_re <= f1_re[DATA_W-1:0];
               Y1_im <= f1_im[DATA_W-1:0];
            end
         end
         // One-cycle pulse so ovf rises the cycle after the overflowing beat lands
         ovf_evt <= en & v2 & beat_ovf;
         ovf     <= ovf_evt | (ovf & ~ovf_clr);
      end
   end
endmodule

// File: tb/tb_bf_radix2_pipe.sv
// Directed bench for bf_radix2_pipe (DATA_W=16, FRAC_W=8, TW_W=16) with hand-computed vectors.
module tb_bf_radix2_pipe;
   logic        clk, rst_n, in_valid, in_ready, scale, out_valid, out_ready, ovf, ovf_clr;
   logic [15:0] A_re, A_im, B_re, B_im, W_re, W_im;
   logic [15:0] Y0_re, Y0_im, Y1_re, Y1_im;

   int checks = 0;
   int errors = 0;

   bf_radix2_pipe #(.DATA_W(16), .FRAC_W(8), .TW_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A_re(A_re), .A_im(A_im), .B_re(B_re), .B_im(B_im),
      .W_re(W_re), .W_im(W_im), .scale(scale),
      .out_valid(out_valid), .out_ready(out_ready),
      .Y0_re(Y0_re), .Y0_im(Y0_im), .Y1_re(Y1_re), .Y1_im(Y1_im),
      .ovf(ovf), .ovf_clr(ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_beat(input logic [15:0] ar, ai, br, bi, wr, wi, input logic sc);
      A_re = ar; A_im = ai; B_re = br; B_im = bi; W_re = wr; W_im = wi; scale = sc;
   endtask

   // Called at a negedge with inputs set; returns edges until out_valid (0 if never)
   task automatic run_beat(output int lat);
      in_valid = 1'b1;
      lat = 0;
      for (int n = 1; n <= 8; n++) begin
         @(posedge clk);
         @(negedge clk);
         in_valid = 1'b0;
         if (out_valid) begin
            lat = n;
            break;
         end
      end
   endtask

   int lat, sent, rcv, stale;
   logic [15:0] held;
   logic [15:0] exp_sat_hi, exp_sat_lo;

   initial begin
`ifdef BF_RADIX2_SAT_EN
      exp_sat_hi = 16'h7FFF; exp_sat_lo = 16'h8000;
`else
      exp_sat_hi = 16'hFE00; exp_sat_lo = 16'h0000;
`endif
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
      set_beat(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
      #2;
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset ovf", 32'(ovf), 32'd0);
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset Y0_re", 32'(Y0_re), 32'h0);
      chk("reset Y1_im", 32'(Y1_im), 32'h0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // Basic butterfly
      set_beat(16'h0100, 16'h0, 16'h0080, 16'h0, 16'h0100, 16'h0, 1'b0);
      run_beat(lat);
      chk("basic latency", 32'(lat), 32'd3);
      chk("basic Y0_re", 32'(Y0_re), 32'h0180);
      chk("basic Y0_im", 32'(Y0_im), 32'h0);
      chk("basic Y1_re", 32'(Y1_re), 32'h0080);
      chk("basic Y1_im", 32'(Y1_im), 32'h0);
      chk("basic ovf", 32'(ovf), 32'd0);
      @(posedge clk); @(negedge clk);
      chk("bubble out_valid", 32'(out_valid), 32'd0);
      chk("bubble hold Y0_re", 32'(Y0_re), 32'h0180);

      // Twiddle -j
      set_beat(16'h0100, 16'h0, 16'h0080, 16'h0, 16'h0000, 16'hFF00, 1'b0);
      run_beat(lat);
      chk("twj latency", 32'(lat), 32'd3);
      chk("twj Y1_re", 32'(Y1_re), 32'h0000);
      chk("twj Y1_im", 32'(Y1_im), 32'hFF80);

      // Round half-up on Y1
      set_beat(16'h0001, 16'h0, 16'h0000, 16'h0, 16'h0080, 16'h0, 1'b0);
      run_beat(lat);
      chk("round+ Y1_re", 32'(Y1_re), 32'h0001);
      set_beat(16'h0000, 16'h0, 16'h0001, 16'h0, 16'h0080, 16'h0, 1'b0);
      run_beat(lat);
      chk("round- Y1_re", 32'(Y1_re), 32'h0000);
      chk("round- Y0_re", 32'(Y0_re), 32'h0001);

      // Scaled beat: both outputs shifted one extra bit with rounding
      set_beat(16'h0003, 16'hFFFD, 16'h0000, 16'h0, 16'h0100, 16'h0, 1'b1);
      run_beat(lat);
      chk("scale Y0_re", 32'(Y0_re), 32'h0002);
      chk("scale Y0_im", 32'(Y0_im), 32'hFFFF);
      chk("scale Y1_re", 32'(Y1_re), 32'h0002);
      chk("scale Y1_im", 32'(Y1_im), 32'hFFFF);

      // Overflow, positive and negative
      set_beat(16'h7F00, 16'h8000, 16'h7F00, 16'h8000, 16'h0100, 16'h0, 1'b0);
      run_beat(lat);
      chk("ovf Y0_re", 32'(Y0_re), 32'(exp_sat_hi));
      chk("ovf Y0_im", 32'(Y0_im), 32'(exp_sat_lo));
      chk("ovf not yet", 32'(ovf), 32'd0);
      @(posedge clk); @(negedge clk);
      chk("ovf set", 32'(ovf), 32'd1);
      set_beat(16'h7F00, 16'h8000, 16'h7F00, 16'h8000, 16'h0100, 16'h0, 1'b1);
      run_beat(lat);
      chk("ovf scaled Y0_re", 32'(Y0_re), 32'h7F00);
      chk("ovf scaled Y0_im", 32'(Y0_im), 32'h8000);
      @(posedge clk); @(negedge clk);
      chk("ovf sticky", 32'(ovf), 32'd1);
      ovf_clr = 1'b1;
      @(posedge clk); @(negedge clk);
      ovf_clr = 1'b0;
      chk("ovf cleared", 32'(ovf), 32'd0);

      // Set and clear in the same cycle: set wins
      set_beat(16'h7F00, 16'h0, 16'h7F00, 16'h0, 16'h0100, 16'h0, 1'b0);
      run_beat(lat);
      ovf_clr = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("ovf set wins", 32'(ovf), 32'd1);
      @(posedge clk); @(negedge clk);
      ovf_clr = 1'b0;
      chk("ovf cleared 2", 32'(ovf), 32'd0);

      // Backpressure: five beats, out_ready low for cycles 2..9
      sent = 0; rcv = 0; held = 16'h0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         out_ready = (cyc < 2) || (cyc >= 10);
         if (sent < 5) begin
            set_beat(16'(16'h0010 * (sent + 1)), 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0, 1'b0);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (cyc == 5) begin
            chk("bp in_ready", 32'(in_ready), 32'd0);
            held = Y0_re;
         end
         if (cyc == 9) begin
            chk("bp out_valid held", 32'(out_valid), 32'd1);
            chk("bp Y0_re held", 32'(Y0_re), 32'h0010);
            chk("bp Y0_re stable", 32'(Y0_re), 32'(held));
         end
         if (out_valid && out_ready) begin
            chk("bp order Y0_re", 32'(Y0_re), 32'(16'h0010 * (rcv + 1)));
            chk("bp order Y1_re", 32'(Y1_re), 32'(16'h0010 * (rcv + 1)));
            rcv++;
         end
         if (in_valid && in_ready) sent++;
         @(posedge clk);
         @(negedge clk);
      end
      chk("bp sent", 32'(sent), 32'd5);
      chk("bp received", 32'(rcv), 32'd5);

      // Mid-stream reset with three beats in flight
      out_ready = 1'b1;
      set_beat(16'h7F00, 16'h0, 16'h7F00, 16'h0, 16'h0100, 16'h0, 1'b0);
      in_valid = 1'b1;
      @(posedge clk); @(posedge clk); @(posedge clk);
      #1;
      chk("pre-reset out_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst ovf", 32'(ovf), 32'd0);
      chk("rst Y0_re", 32'(Y0_re), 32'h0);
      chk("rst in_ready", 32'(in_ready), 32'd1);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      stale = 0;
      for (int n = 0; n < 8; n++) begin
         @(posedge clk);
         #1;
         if (out_valid) stale++;
      end
      chk("no stale beats", 32'(stale), 32'd0);
      chk("post-reset ovf", 32'(ovf), 32'd0);

      @(negedge clk);
      set_beat(16'h0100, 16'h0, 16'h0080, 16'h0, 16'h0100, 16'h0, 1'b0);
      run_beat(lat);
      chk("post-reset latency", 32'(lat), 32'd3);
      chk("post-reset Y0_re", 32'(Y0_re), 32'h0180);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
